spi_frame_rx: RTL

- Parametrised SPI slave frame receiver for MCU-to-FPGA transfers. Successor to the fixed 128-bit, load-framed receiver.
- Runs entirely in the system clock domain: synchronises and oversamples sck, sdi and cs_n.
- Captures exactly FRAME_BITS bits per chip-select window and delivers each frame through a valid/ack handshake.
- Echoes the previously captured frame on sdo. Flags short frames, long frames and overruns.

---
 rtl/spi_frame_rx_if.sv | 22 ++
 rtl/spi_frame_rx.sv | 109 ++++++++++
 2 files changed

// File: rtl/spi_frame_rx_if.sv
// spi_frame_rx_if: SPI pins plus frame handshake/error signals of spi_frame_rx
interface spi_frame_rx_if #(parameter int FRAME_BITS = 128);
  logic                  sck;
  logic                  sdi;
  logic                  cs_n;
  logic                  sdo;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_ack;
  logic                  short_frame;
  logic                  long_frame;
  logic                  overrun;
  logic                  err_clr;
  modport master (
    output sck, sdi, cs_n, frame_ack, err_clr,
    input  sdo, frame_data, frame_valid, short_frame, long_frame, overrun
  );
  modport slave (
    input  sck, sdi, cs_n, frame_ack, err_clr,
    output sdo, frame_data, frame_valid, short_frame, long_frame, overrun
  );
endinterface

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled SPI slave capturing FRAME_BITS-bit frames with valid/ack handoff and echo on sdo
module spi_frame_rx #(
  parameter int FRAME_BITS  = 128,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  spi_frame_rx_if.slave bus
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, FULL} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sck_q, sdi_q, cs_q;
  logic sck_d, sck_s, sdi_s, cs_s;
  logic lead, trail, sample, shift_e, shift_ok;
  logic [CW-1:0] count;
  logic [FRAME_BITS-1:0] shift_reg, echo, frame_data;
  logic extra, frame_valid, overrun, short_frame, long_frame;
  logic load, done, short_p, long_p;
  // cs_n sync resets low so WAIT_IDLE must see a real deassertion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_q <= {SYNC_STAGES{CPOL}};
      sdi_q <= '0;
      cs_q  <= '0;
      sck_d <= CPOL;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], bus.sck};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], bus.sdi};
      cs_q  <= {cs_q[SYNC_STAGES-2:0], bus.cs_n};
      sck_d <= sck_q[SYNC_STAGES-1];
    end
  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_q[SYNC_STAGES-1];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign lead     = (sck_s != CPOL) && (sck_d == CPOL);
  assign trail    = (sck_s == CPOL) && (sck_d != CPOL);
  assign sample   = CPHA ? trail : lead;
  assign shift_e  = CPHA ? lead : trail;
  // with CPHA=1 the first leading edge precedes any sample and must not advance sdo
  assign shift_ok = shift_e && (!CPHA || count != '0);
  always_comb begin
    state_n = state;
    load    = 1'b0;
    done    = 1'b0;
    short_p = 1'b0;
    long_p  = 1'b0;
    case (state)
      WAIT_IDLE: if (cs_s) state_n = IDLE;
      IDLE: if (!cs_s) begin
        state_n = SHIFT;
        load    = 1'b1;
      end
      SHIFT: if (count == FULL_CNT) begin
        state_n = FULL;
        done    = 1'b1;
      end else if (cs_s) begin
        state_n = IDLE;
        short_p = count != '0;
      end
      default: if (cs_s) begin
        state_n = IDLE;
        long_p  = extra;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= WAIT_IDLE;
      count       <= '0;
      shift_reg   <= '0;
      echo        <= '0;
      extra       <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      short_frame <= 1'b0;
      long_frame  <= 1'b0;
    end else begin
      state       <= state_n;
      short_frame <= short_p;
      long_frame  <= long_p;
      if (load) begin
        count     <= '0;
        shift_reg <= '0;
        echo      <= frame_data;
        extra     <= 1'b0;
      end else if (state == SHIFT && count != FULL_CNT) begin
        if (sample) begin
          shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_s};
          count     <= count + 1'b1;
        end
        if (shift_ok) echo <= {echo[FRAME_BITS-2:0], 1'b0};
      end
      if ((state == FULL || done) && sample) extra <= 1'b1;
      if (done) frame_data <= shift_reg;
      frame_valid <= done || (frame_valid && !bus.frame_ack);
      overrun     <= (done && frame_valid && !bus.frame_ack) || (overrun && !bus.err_clr);
    end
  assign bus.sdo         = (state == SHIFT || state == FULL) && echo[FRAME_BITS-1];
  assign bus.frame_data  = frame_data;
  assign bus.frame_valid = frame_valid;
  assign bus.short_frame = short_frame;
  assign bus.long_frame  = long_frame;
  assign bus.overrun     = overrun;
endmodule
